// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit over a word-wide memory port; sub-word stores are read-modify-write.
// Latency: error 1, load/word store 3, sub-word store 5 cycles; requests arriving while busy are dropped.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        mem_rd_en_o,
  output logic        mem_wr_en_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int CW     = (CW_RAW < 4) ? 4 : CW_RAW;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] rdata_d, mem_addr_d, mem_data_d;
  logic        ready_d, err_d, busy_d, rd_en_d, wr_en_d;

  logic        misaligned;
  logic [4:0]  sh;
  logic [31:0] lane, base_mask, merged, extracted;

  assign misaligned = (size_i == 2'b11) ||
                      (size_i == 2'b01 && addr_i[0]) ||
                      (size_i == 2'b10 && addr_i[1:0] != 2'b00);

  // Little-endian lane select and merge for the captured byte offset.
  assign sh        = {off_q, 3'b000};
  assign lane      = mem_data_i >> sh;
  assign base_mask = (size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
  assign merged    = (mem_data_i & ~(base_mask << sh)) | ((wdata_q & base_mask) << sh);

  always_comb begin
    extracted = lane;
    case (size_q)
      2'b00:   extracted = uns_q ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   extracted = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: extracted = mem_data_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_o;
    mem_addr_d = mem_addr_o;
    mem_data_d = mem_data_o;
    rd_en_d    = mem_rd_en_o;
    wr_en_d    = mem_wr_en_o;
    busy_d     = busy_o;
    ready_d    = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d       = we_i;
          size_d     = size_i;
          uns_d      = unsigned_i;
          off_d      = addr_i[1:0];
          wdata_d    = wdata_i;
          mem_addr_d = {addr_i[31:2], 2'b00};
          cnt_d      = '0;
          busy_d     = 1'b1;
          if (misaligned) begin
            state_d = RESP;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end else if (we_i && size_i == 2'b10) begin
            state_d    = WRITE;
            wr_en_d    = 1'b1;
            mem_data_d = wdata_i;
          end else begin
            state_d = READ;
            rd_en_d = 1'b1;
          end
        end
      end
      READ: begin
        if (mem_ack_i) begin
          rd_en_d = 1'b0;
          if (we_q) begin
            state_d    = WRITE;
            wr_en_d    = 1'b1;
            mem_data_d = merged;
            cnt_d      = '0;
          end else begin
            state_d = RESP;
            ready_d = 1'b1;
            rdata_d = extracted;
          end
        end else if (cnt_q == CNT_LAST) begin
          rd_en_d = 1'b0;
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WRITE: begin
        if (mem_ack_i) begin
          wr_en_d = 1'b0;
          state_d = RESP;
          ready_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          wr_en_d = 1'b0;
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rdata_o     <= '0;
      ready_o     <= 1'b0;
      err_o       <= 1'b0;
      busy_o      <= 1'b0;
      mem_rd_en_o <= 1'b0;
      mem_wr_en_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rdata_o     <= rdata_d;
      ready_o     <= ready_d;
      err_o       <= err_d;
      busy_o      <= busy_d;
      mem_rd_en_o <= rd_en_d;
      mem_wr_en_o <= wr_en_d;
      mem_addr_o  <= mem_addr_d;
      mem_data_o  <= mem_data_d;
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max cycles waiting for mem_ack_i per memory phase.
REQ-002 SHALL have ports:
- clk  in  1  the only clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  1  access request, sampled in IDLE only.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  00 byte, 01 halfword, 10 word, 11 invalid.
- unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-aligned.
- rdata_o  out  32  extended load result.
- ready_o  out  1  one-cycle completion pulse.
- err_o  out  1  error flag, valid with ready_o.
- busy_o  out  1  high in every state except IDLE.
- mem_rd_en_o  out  1  word read request to memory.
- mem_wr_en_o  out  1  word write request to memory.
- mem_addr_o  out  32  word address {addr[31:2],2'b00}.
- mem_data_o  out  32  write word.
- mem_data_i  in  32  read word, valid only while mem_rd_en_o is high and mem_ack_i is high.
- mem_ack_i  in  1  registered memory acknowledge, earliest one cycle after the enable rises.

Function
REQ-003 SHALL implement FSM states IDLE, READ, WRITE, RESP; all outputs driven from registers.
REQ-004 In IDLE, req_i=1 SHALL capture we/size/unsigned/addr/wdata and leave IDLE on the same edge.
REQ-005 Misalignment SHALL be defined as: size 01 with addr[0]=1, size 10 with addr[1:0]!=0, or size 11.
REQ-006 Misaligned requests SHALL go IDLE->RESP with err_o=1 and no memory enable asserted.
REQ-007 Loads and sub-word stores SHALL go IDLE->READ; word stores SHALL go IDLE->WRITE.
REQ-008 In READ, mem_rd_en_o SHALL be held at 1 until mem_ack_i=1; mem_data_i SHALL be sampled in that ack cycle; the enable SHALL drop on the following edge.
REQ-009 After READ, loads SHALL go to RESP; sub-word stores SHALL go to WRITE.
REQ-010 Sub-word stores SHALL write the read word with the addressed lane(s) replaced by wdata_i[7:0] or [15:0]; lanes are little-endian, byte k at bits 8k+7:8k.
REQ-011 In WRITE, mem_wr_en_o SHALL be held at 1 with a stable mem_data_o until mem_ack_i=1, then go to RESP.
REQ-012 mem_rd_en_o and mem_wr_en_o SHALL never be high in the same cycle.
REQ-013 In RESP, ready_o=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-014 rdata_o SHALL hold the extracted lane, sign- or zero-extended to 32 bits, from RESP until the next load reaches RESP; stores and errors SHALL leave rdata_o unchanged.
REQ-015 A 4-bit+ wait counter SHALL clear on entering READ or WRITE and increment each cycle without ack.
- At count TIMEOUT_CYCLES-1 without ack: drop the enable, go to RESP with err_o=1; no write is issued for a timed-out RMW read.
REQ-016 req_i while busy_o=1 SHALL be ignored; there is no queue.
REQ-017 Nominal latency from the accept edge to the ready_o cycle: error 1 cycle; load or word store 3 cycles; sub-word store 5 cycles.
REQ-018 mem_addr_o SHALL be stable from the first enable cycle through the ack cycle.

Reset
REQ-019 rst_n=0 SHALL immediately force state IDLE and drive all outputs to 0, including mem enables, rdata_o, ready_o, err_o and busy_o.
REQ-020 Reset mid-transaction SHALL abandon the access with no ready_o pulse; the first request after release SHALL behave normally.

Verification
REQ-021 Load word: mem[1]=0xDEADBEEF, req load size 10 addr 0x4 -> rd_en for 2 cycles, ready_o 3 cycles after accept, rdata_o=0xDEADBEEF, err_o=0.
REQ-022 Byte loads: mem[0]=0x80FF7F01, load addr 0x3, unsigned_i=0 -> rdata_o=0xFFFFFF80; then load addr 0x1, unsigned_i=1 -> rdata_o=0x0000007F.
REQ-023 Byte store: mem[2]=0x11223344, store size 00 addr 0x9 wdata 0xAB -> one read then one write of 0x1122AB44, ready_o 5 cycles after accept.
REQ-024 Misaligned: halfword load addr 0x3 -> no enable asserted, ready_o and err_o both 1 the cycle after accept, rdata_o unchanged.
REQ-025 Timeout: mem_ack_i tied 0, word load -> rd_en high 16 cycles then drops, ready_o=1 with err_o=1.
REQ-026 Reset mid-op: rst_n low during WRITE -> mem_wr_en_o 0 with no edge needed, no ready_o pulse; the next load completes correctly.
